// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and the data memory port: a
// request/grant/rvalid handshake FSM with byte lanes and load extension.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [1:0]              mem_data_type_i,
    input  logic                    mem_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic                    mem_ready_o,
    output logic                    mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_err_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_GNT    = 2'd1;
    localparam logic [1:0] WAIT_RVALID = 2'd2;

    localparam logic [1:0] TYPE_WORD  = 2'b00;
    localparam logic [1:0] TYPE_HALF  = 2'b01;
    localparam logic [1:0] TYPE_BYTE  = 2'b10;
    localparam logic [1:0] TYPE_DWORD = 2'b11;

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic                  sign_q;
    logic [1:0]            type_q;
    logic [OFF_W-1:0]      off_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [OFF_W-1:0]      req_off;
    logic                  aligned;
    logic [7:0]            be_base;
    logic [BE_W-1:0]       req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  idle;
    logic                  accept;
    logic                  legal_req;

    assign req_off = mem_addr_i[OFF_W-1:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        aligned = 1'b0;
        be_base = 8'h00;
        case (mem_data_type_i)
            TYPE_BYTE: begin aligned = 1'b1;                       be_base = 8'h01; end
            TYPE_HALF: begin aligned = ~mem_addr_i[0];             be_base = 8'h03; end
            TYPE_WORD: begin aligned = (mem_addr_i[1:0] == 2'b00); be_base = 8'h0F; end
            default:   begin
                aligned = (DATA_WIDTH == 64) && (mem_addr_i[2:0] == 3'b000);
                be_base = 8'hFF;
            end
        endcase
    end

    assign req_be    = BE_W'(be_base) << req_off;
    assign req_wdata = mem_wdata_i << {req_off, 3'b000};
    assign req_addr  = {mem_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    assign idle        = rst_ni && (state_q == IDLE);
    assign accept      = idle && mem_req_i;
    assign legal_req   = accept && aligned;
    assign mem_ready_o = idle;
    assign mem_err_o   = accept && !aligned;
    assign data_req_o  = legal_req || (rst_ni && (state_q == WAIT_GNT));

    // In IDLE the bus follows the MEM inputs; while waiting for grant it is held from registers.
    always_comb begin
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (legal_req) begin
            data_addr_o  = req_addr;
            data_we_o    = mem_we_i;
            data_be_o    = req_be;
            data_wdata_o = req_wdata;
        end else if (data_req_o) begin
            data_addr_o  = addr_q;
            data_we_o    = we_q;
            data_be_o    = be_q;
            data_wdata_o = wdata_q;
        end
    end

    logic [DATA_WIDTH-1:0] rshift;
    logic [DATA_WIDTH-1:0] rext;

    assign rshift = data_rdata_i >> {off_q, 3'b000};

    always_comb begin
        rext = rshift;
        case (type_q)
            TYPE_BYTE: rext = sign_q ? DATA_WIDTH'($signed(rshift[7:0]))  : DATA_WIDTH'(rshift[7:0]);
            TYPE_HALF: rext = sign_q ? DATA_WIDTH'($signed(rshift[15:0])) : DATA_WIDTH'(rshift[15:0]);
            TYPE_WORD: rext = sign_q ? DATA_WIDTH'($signed(rshift[31:0])) : DATA_WIDTH'(rshift[31:0]);
            default:   rext = rshift;
        endcase
    end

    assign mem_rvalid_o = rst_ni && (state_q == WAIT_RVALID) && data_rvalid_i;
    assign mem_rdata_o  = (mem_rvalid_o && !we_q) ? rext : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            type_q  <= TYPE_WORD;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (legal_req) begin
                        addr_q  <= req_addr;
                        we_q    <= mem_we_i;
                        sign_q  <= mem_sign_ext_i;
                        type_q  <= mem_data_type_i;
                        off_q   <= req_off;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: a 32-bit and a 64-bit instance share stimulus and are
// compared against an arithmetic model of the access rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_sx;
    logic [1:0]  mem_ty;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, data_rdata;
    logic        data_gnt, data_rvalid;

    logic        req32, we32, ready32, rvalid32, err32;
    logic [3:0]  be32;
    logic [31:0] addr32, wdata32, rdata32;
    logic        req64, we64, ready64, rvalid64, err64;
    logic [7:0]  be64;
    logic [31:0] addr64;
    logic [63:0] wdata64, rdata64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_o(req32), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_addr_o(addr32), .data_we_o(we32), .data_be_o(be32),
        .data_wdata_o(wdata32), .data_rdata_i(data_rdata[31:0]),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_data_type_i(mem_ty),
        .mem_sign_ext_i(mem_sx), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata[31:0]),
        .mem_ready_o(ready32), .mem_rvalid_o(rvalid32), .mem_rdata_o(rdata32),
        .mem_err_o(err32)
    );

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_o(req64), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_addr_o(addr64), .data_we_o(we64), .data_be_o(be64),
        .data_wdata_o(wdata64), .data_rdata_i(data_rdata),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_data_type_i(mem_ty),
        .mem_sign_ext_i(mem_sx), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_ready_o(ready64), .mem_rvalid_o(rvalid64), .mem_rdata_o(rdata64),
        .mem_err_o(err64)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [1:0] ty);
        case (ty)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] m_mask(input int nbytes);
        if (nbytes >= 8) return '1;
        return (64'd1 << (8 * nbytes)) - 64'd1;
    endfunction

    function automatic logic m_legal(input int dw, input logic [1:0] ty, input logic [31:0] a);
        int sz = m_size(ty);
        if (sz * 8 > dw) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic int m_off(input int dw, input logic [31:0] a);
        return int'(a % (dw / 8));
    endfunction

    function automatic logic [63:0] m_be(input int dw, input logic [1:0] ty, input logic [31:0] a);
        return ((64'd1 << m_size(ty)) - 64'd1) << m_off(dw, a);
    endfunction

    function automatic logic [63:0] m_wdata(input int dw, input logic [63:0] wd, input logic [31:0] a);
        return ((wd & m_mask(dw / 8)) << (8 * m_off(dw, a))) & m_mask(dw / 8);
    endfunction

    function automatic logic [63:0] m_rdata(input int dw, input logic [1:0] ty, input logic sx,
                                            input logic [31:0] a, input logic [63:0] rd);
        int sz = m_size(ty);
        logic [63:0] v;
        v = ((rd & m_mask(dw / 8)) >> (8 * m_off(dw, a))) & m_mask(sz);
        if (sx && v[8 * sz - 1]) v = v | ~m_mask(sz);
        return v & m_mask(dw / 8);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input int w, input logic e_req, input logic e_we,
                            input logic [63:0] e_addr, input logic [63:0] e_be,
                            input logic [63:0] e_wdata, input logic e_ready,
                            input logic e_rvalid, input logic [63:0] e_rdata, input logic e_err);
        logic o_req, o_we, o_ready, o_rvalid, o_err;
        logic [63:0] o_addr, o_be, o_wdata, o_rdata;
        if (w == 32) begin
            o_req = req32; o_we = we32; o_ready = ready32; o_rvalid = rvalid32; o_err = err32;
            o_addr = 64'(addr32); o_be = 64'(be32); o_wdata = 64'(wdata32); o_rdata = 64'(rdata32);
        end else begin
            o_req = req64; o_we = we64; o_ready = ready64; o_rvalid = rvalid64; o_err = err64;
            o_addr = 64'(addr64); o_be = 64'(be64); o_wdata = wdata64; o_rdata = rdata64;
        end
        check($sformatf("w%0d.req", w), 64'(o_req), 64'(e_req));
        check($sformatf("w%0d.ready", w), 64'(o_ready), 64'(e_ready));
        check($sformatf("w%0d.rvalid", w), 64'(o_rvalid), 64'(e_rvalid));
        check($sformatf("w%0d.err", w), 64'(o_err), 64'(e_err));
        if (e_req) begin
            check($sformatf("w%0d.addr", w), o_addr, e_addr);
            check($sformatf("w%0d.we", w), 64'(o_we), 64'(e_we));
            check($sformatf("w%0d.be", w), o_be, e_be);
            check($sformatf("w%0d.wdata", w), o_wdata, e_wdata);
        end else begin
            check($sformatf("w%0d.we_idle", w), 64'(o_we), 64'd0);
        end
        if (e_rvalid) check($sformatf("w%0d.rdata", w), o_rdata, e_rdata);
    endtask

    task automatic chk_reset();
        check("rst.req32", 64'(req32), 64'd0);     check("rst.req64", 64'(req64), 64'd0);
        check("rst.ready32", 64'(ready32), 64'd0); check("rst.ready64", 64'(ready64), 64'd0);
        check("rst.rvalid32", 64'(rvalid32), 64'd0); check("rst.rvalid64", 64'(rvalid64), 64'd0);
        check("rst.err32", 64'(err32), 64'd0);     check("rst.err64", 64'(err64), 64'd0);
        check("rst.addr32", 64'(addr32), 64'd0);   check("rst.addr64", 64'(addr64), 64'd0);
        check("rst.be32", 64'(be32), 64'd0);       check("rst.be64", 64'(be64), 64'd0);
        check("rst.wdata32", 64'(wdata32), 64'd0); check("rst.wdata64", wdata64, 64'd0);
        check("rst.we32", 64'(we32), 64'd0);       check("rst.we64", 64'(we64), 64'd0);
        check("rst.rdata32", 64'(rdata32), 64'd0); check("rst.rdata64", rdata64, 64'd0);
    endtask

    task automatic scramble_mem_inputs();
        mem_addr  = $urandom;
        mem_wdata = {$urandom, $urandom};
        mem_we    = 1'($urandom);
        mem_ty    = 2'($urandom);
        mem_sx    = 1'($urandom);
    endtask

    // One transaction: accept, gd cycles of grant delay, rdl cycles before rvalid.
    task automatic txn(input logic we, input logic [1:0] ty, input logic sx, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input int gd, input int rdl);
        logic l32, l64;
        logic [63:0] ad32, ad64, b32, b64, w32, w64, r32, r64;
        l32  = m_legal(32, ty, a);
        l64  = m_legal(64, ty, a);
        ad32 = 64'(a) - 64'(m_off(32, a));
        ad64 = 64'(a) - 64'(m_off(64, a));
        b32  = m_be(32, ty, a);
        b64  = m_be(64, ty, a);
        w32  = m_wdata(32, wd, a);
        w64  = m_wdata(64, wd, a);
        r32  = we ? 64'd0 : m_rdata(32, ty, sx, a, rd);
        r64  = we ? 64'd0 : m_rdata(64, ty, sx, a, rd);

        mem_req = 1'b1; mem_we = we; mem_ty = ty; mem_sx = sx; mem_addr = a; mem_wdata = wd;
        data_gnt = (gd == 0); data_rvalid = 1'b0; data_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk_port(32, l32, we, ad32, b32, w32, 1'b1, 1'b0, 64'd0, !l32);
        chk_port(64, l64, we, ad64, b64, w64, 1'b1, 1'b0, 64'd0, !l64);
        @(posedge clk); #1;
        mem_req = 1'b0;
        data_gnt = 1'b0;
        scramble_mem_inputs();
        if (!l64) return;

        for (int i = 1; i <= gd; i++) begin
            data_gnt = (i == gd);
            @(negedge clk);
            chk_port(32, l32, we, ad32, b32, w32, !l32, 1'b0, 64'd0, 1'b0);
            chk_port(64, 1'b1, we, ad64, b64, w64, 1'b0, 1'b0, 64'd0, 1'b0);
            @(posedge clk); #1;
            scramble_mem_inputs();
        end
        data_gnt = 1'b0;

        for (int i = 0; i < rdl; i++) begin
            data_gnt = 1'($urandom);
            @(negedge clk);
            chk_port(32, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, !l32, 1'b0, 64'd0, 1'b0);
            chk_port(64, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
            @(posedge clk); #1;
        end

        data_rvalid = 1'b1; data_rdata = rd; data_gnt = 1'($urandom);
        @(negedge clk);
        chk_port(32, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, !l32, l32, r32, 1'b0);
        chk_port(64, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, r64, 1'b0);
        @(posedge clk); #1;
        data_rvalid = 1'b0; data_gnt = 1'b0;
    endtask

    initial begin
        // Reset with a pending request: bus must stay quiet.
        rst_n = 1'b0; mem_req = 1'b1; mem_we = 1'b1; mem_ty = 2'b00; mem_sx = 1'b0;
        mem_addr = 32'h10; mem_wdata = 64'hDEAD_BEEF; data_gnt = 1'b1; data_rvalid = 1'b0;
        data_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; mem_req = 1'b0; data_gnt = 1'b0;

        // Directed cases.
        txn(1'b0, 2'b10, 1'b1, 32'h1003, 64'd0, 64'h0000_0000_80AA_BBCC, 0, 0);
        txn(1'b1, 2'b01, 1'b0, 32'h2002, 64'h0000_BEEF, 64'd0, 3, 1);
        txn(1'b0, 2'b00, 1'b0, 32'h3001, 64'd0, 64'd0, 0, 0);
        txn(1'b0, 2'b00, 1'b1, 32'h3004, 64'd0, 64'h1234_5678_8765_4321, 0, 0);
        txn(1'b0, 2'b11, 1'b0, 32'h8, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 0);
        txn(1'b0, 2'b00, 1'b0, 32'hC, 64'd0, 64'hF000_0000_0000_0000, 0, 2);
        txn(1'b1, 2'b11, 1'b0, 32'h4, 64'h1122_3344_5566_7788, 64'd0, 0, 0);

        // Spurious rvalid in IDLE.
        data_rvalid = 1'b1; data_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk_port(32, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        chk_port(64, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        @(posedge clk); #1;
        data_rvalid = 1'b0;

        // Reset while waiting for rvalid; a late rvalid must be dropped.
        mem_req = 1'b1; mem_we = 1'b0; mem_ty = 2'b00; mem_addr = 32'h40; data_gnt = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b0; data_gnt = 1'b0;
        rst_n = 1'b0; data_rvalid = 1'b1; data_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_port(32, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        chk_port(64, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        @(posedge clk); #1;
        data_rvalid = 1'b0;

        // Randomised traffic, mostly aligned.
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  ty;
            logic [31:0] a;
            ty = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % m_size(ty));
            txn(1'($urandom), ty, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit between the MEM stage and the data memory port. It replaces the pass-through unit with a request/grant/rvalid handshake FSM and byte-enable generation. It also does write-data lane alignment, load extraction with sign/zero extension, and misalignment detection. One transaction is outstanding at a time. The MEM stage stalls on `mem_ready_o`.

## Interface
- `DATA_WIDTH`, 32: data bus width. Legal values are 32 and 64. `BE_W = DATA_WIDTH/8`, `OFF_W = log2(BE_W)`.
- `ADDR_WIDTH`, 32: address width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `data_req_o`  out  1  memory request.
- `data_gnt_i`  in  1  memory grant.
- `data_rvalid_i`  in  1  memory response valid.
- `data_addr_o`  out  ADDR_WIDTH  address, with the low OFF_W bits forced to 0.
- `data_we_o`  out  1  write enable.
- `data_be_o`  out  BE_W  byte enables.
- `data_wdata_o`  out  DATA_WIDTH  lane-aligned write data.
- `data_rdata_i`  in  DATA_WIDTH  read data.
- `mem_req_i`  in  1  request from the MEM stage.
- `mem_we_i`  in  1  1 = store.
- `mem_data_type_i`  in  2  access size: 00 word, 01 half, 10 byte, 11 doubleword (legal only when DATA_WIDTH=64).
- `mem_sign_ext_i`  in  1  1 = sign-extend loaded data.
- `mem_addr_i`  in  ADDR_WIDTH  byte address.
- `mem_wdata_i`  in  DATA_WIDTH  store data, right-aligned.
- `mem_ready_o`  out  1  unit can accept a request.
- `mem_rvalid_o`  out  1  transaction complete (one-cycle pulse).
- `mem_rdata_o`  out  DATA_WIDTH  extended load data.
- `mem_err_o`  out  1  misaligned or illegal access (one-cycle pulse).

## Operation
- **States:** IDLE, WAIT_GNT, WAIT_RVALID.
- **Acceptance:** a request is accepted when `mem_req_i && mem_ready_o`. `mem_ready_o` = 1 only in IDLE.
- **Alignment check:**
  - Half requires `addr[0]` = 0.
  - Word requires `addr[1:0]` = 0.
  - Doubleword requires `addr[2:0]` = 0.
  - Type 11 with DATA_WIDTH=32 is illegal.
  - Failing requests assert `mem_err_o` in the acceptance cycle. No bus request is made, the FSM stays in IDLE, and `mem_rvalid_o` is not asserted.
- **Legal request in IDLE:**
  - `data_req_o` = 1 combinationally in the same cycle, with the bus fields derived from the inputs.
  - addr, we, be, wdata, type, sign and offset are captured in registers.
  - If `data_gnt_i` = 1, go to WAIT_RVALID; otherwise go to WAIT_GNT.
- **WAIT_GNT:**
  - `data_req_o` = 1; bus fields are driven from the registers and held stable.
  - On `data_gnt_i`, go to WAIT_RVALID.
- **WAIT_RVALID:**
  - `data_req_o` = 0.
  - On `data_rvalid_i`: `mem_rvalid_o` = 1 in the same cycle, then go to IDLE.
  - `mem_rvalid_o` also pulses for stores; `mem_rdata_o` is 0 for stores.
  - Any `data_gnt_i` in this state is ignored.
- **Byte enables:** `data_be_o` = {byte: 1, half: 2'b11, word: 4'hF, dword: 8'hFF}, zero-extended to BE_W bits, then shifted left by `off = addr[OFF_W-1:0]`.
- **Write data:** `data_wdata_o` = `mem_wdata_i << (8*off)`; bits shifted out are dropped.
- **Read data:** `(data_rdata_i >> 8*off)` is truncated to the access size, then sign- or zero-extended to DATA_WIDTH.
- **`data_we_o`** is 0 whenever `data_req_o` = 0.
- **`data_rvalid_i` in IDLE or WAIT_GNT** (spurious) is ignored. No output changes.

## Timing
- **Reset:** while `rst_ni` = 0, `data_req_o`, `mem_ready_o`, `mem_rvalid_o` and `mem_err_o` are forced to 0. `data_addr_o`, `data_be_o`, `data_wdata_o`, `data_we_o` and `mem_rdata_o` are 0.
- **Mid-transaction reset:** the first edge with `rst_ni` = 0 sets the FSM to IDLE and clears the registers. A late `data_rvalid_i` after reset release is ignored.
- **Minimum latency:** the request is granted in the acceptance cycle (cycle 0) and `data_rvalid_i` arrives in cycle 1. `mem_rvalid_o` is then asserted in cycle 1.
- **Throughput:** one transaction per 2 cycles at best. The next request is accepted in the cycle after the `mem_rvalid_o` cycle, i.e. in IDLE.
- **Combinational paths:**
  - `mem_req_i`/`mem_addr_i` → `data_req_o`/bus fields (IDLE only).
  - `data_rvalid_i`/`data_rdata_i` → `mem_rvalid_o`/`mem_rdata_o`.
  - `data_gnt_i` has no combinational path to any output.
- **Stability:** from `data_req_o` rising until grant, the bus fields must stay constant even if the `mem_*` inputs change.

## Test plan
- **Load byte with sign extension:** DATA_WIDTH=32, `data_gnt_i` tied to 1, load byte at 0x1003 with `mem_sign_ext_i` = 1, rvalid next cycle with rdata 0x80AABBCC. Expect `data_be_o` = 4'b1000, `data_addr_o` = 0x1000, and `mem_rdata_o` = 0xFFFFFF80 with `mem_rvalid_o` in cycle 1.
- **Store half with delayed grant:** store half at 0x2002 with wdata 0x0000BEEF; grant delayed 3 cycles while `mem_addr_i`/`mem_wdata_i` are changed. Expect `data_req_o` held for 4 cycles, `data_be_o` = 4'b1100, `data_wdata_o` = 0xBEEF0000 stable throughout, and `mem_ready_o` = 0 until IDLE.
- **Misaligned word load:** word load at 0x3001. Expect `mem_err_o` pulse in the same cycle, `data_req_o` = 0, and no `mem_rvalid_o`. The next legal request is accepted the following cycle.
- **64-bit doubleword and zero extension:** DATA_WIDTH=64, doubleword load at 0x8 with rdata 0x0123456789ABCDEF. Expect `data_be_o` = 8'hFF and `mem_rdata_o` equal to rdata. Then a word load at 0xC with sign_ext=0 and rdata 0xF000000000000000. Expect `data_be_o` = 8'hF0 and `mem_rdata_o` = 0x00000000F0000000.
- **Reset in WAIT_RVALID:** reset asserted for 1 cycle in WAIT_RVALID, then rvalid pulsed after release. Expect no `mem_rvalid_o`, the FSM in IDLE, and `mem_ready_o` = 1.
- **Spurious rvalid in IDLE:** `data_rvalid_i` pulsed in IDLE. Expect no output change.
